pwm_ramp_ctrl: RTL

//  Duty-cycle ramp sequencer in front of the 10-step PWM generator. Takes a target duty over a

---
 rtl/pwm_ctrl_pkg.sv | 30 +++
 rtl/pwm_step_timer.sv | 32 +++
 rtl/pwm_ramp_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: constants, state type and helper shared between the PWM ramp
// controller and the 10-step PWM generator it drives.
//   DUTY_W   - duty bus width
//   DUTY_MIN - lowest duty the generator accepts
//   DUTY_MAX - highest duty the generator accepts
//   DUTY_RST - generator duty after reset
//   state_t  - ramp controller states {IDLE, RAMP}
//   clamp_duty() - limits a requested duty to [DUTY_MIN, DUTY_MAX]
package pwm_ctrl_pkg;

    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MIN = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(9);
    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(5);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        if (d < DUTY_MIN)
            return DUTY_MIN;
        else if (d > DUTY_MAX)
            return DUTY_MAX;
        else
            return d;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// pwm_step_timer: free-running step divider for the ramp controller.
// Counts up while clear is low and raises tick for one cycle when the count
// reaches STEP_DIV-1, wrapping back to 0 on the following edge.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset
//   clear in  hold the counter at 0 (no tick while high)
//   tick  out one-cycle step strobe
module pwm_step_timer #(
    parameter int STEP_DIV = 10,
    parameter int DIV_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] count;

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle ramp sequencer for the 10-step PWM generator.
// Accepts a target duty over valid/ready and walks the generator towards it
// with single-cycle increase/decrease pulses spaced STEP_DIV clocks apart,
// keeping a shadow copy of the generator's duty register.
// Optional build macro MANUAL_BTN_EN adds two asynchronous pushbuttons that
// nudge the duty up/down by one step while idle.
// Ports:
//   clk          in   clock (shared with the generator)
//   reset        in   synchronous active-high reset
//   i_tgt_valid  in   target request valid
//   i_tgt_duty   in   requested duty (clamped to the legal range)
//   o_tgt_ready  out  high while idle; request taken on valid&ready
//   i_abort      in   stop an active ramp at the current duty
//   o_increase   out  one-cycle pulse to generator i_increase
//   o_decrease   out  one-cycle pulse to generator i_decrease
//   o_duty       out  shadow duty
//   o_busy       out  ramp in progress
//   o_done       out  one-cycle pulse when the target is reached
//   i_btn_up     in   (MANUAL_BTN_EN) asynchronous up button
//   i_btn_dn     in   (MANUAL_BTN_EN) asynchronous down button
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP_DIV = 10,
    parameter int DIV_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_tgt_valid,
    input  logic [DUTY_W-1:0] i_tgt_duty,
    output logic              o_tgt_ready,
    input  logic              i_abort,
    output logic              o_increase,
    output logic              o_decrease,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_busy,
    output logic              o_done
`ifdef MANUAL_BTN_EN
    ,
    input  logic              i_btn_up,
    input  logic              i_btn_dn
`endif
);

    state_t            state, state_n;
    logic [DUTY_W-1:0] duty, duty_n;
    logic [DUTY_W-1:0] tgt, tgt_n;
    logic [DUTY_W-1:0] req;
    logic              inc_n, dec_n, done_n;
    logic              tick;

    assign req = clamp_duty(i_tgt_duty);

    // The timer only runs during a ramp, so it always restarts from 0 at accept.
    pwm_step_timer #(
        .STEP_DIV(STEP_DIV),
        .DIV_W   (DIV_W)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(state != RAMP),
        .tick (tick)
    );

`ifdef MANUAL_BTN_EN
    // [0] and [1] form the synchroniser, [2] holds the previous synced level.
    logic [2:0] up_sr, dn_sr;
    logic       up_edge, dn_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            up_sr <= '0;
            dn_sr <= '0;
        end else begin
            up_sr <= {up_sr[1:0], i_btn_up};
            dn_sr <= {dn_sr[1:0], i_btn_dn};
        end
    end

    assign up_edge = up_sr[1] & ~up_sr[2];
    assign dn_edge = dn_sr[1] & ~dn_sr[2];
`endif

    always_comb begin
        state_n = state;
        duty_n  = duty;
        tgt_n   = tgt;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (i_tgt_valid) begin
                    tgt_n = req;
                    if (req == duty)
                        done_n = 1'b1;
                    else
                        state_n = RAMP;
                end
`ifdef MANUAL_BTN_EN
                // A handshake takes priority; simultaneous up+down cancel.
                else if (up_edge && !dn_edge) begin
                    if (duty < DUTY_MAX) begin
                        inc_n  = 1'b1;
                        duty_n = duty + 1'b1;
                    end
                end else if (dn_edge && !up_edge) begin
                    if (duty > DUTY_MIN) begin
                        dec_n  = 1'b1;
                        duty_n = duty - 1'b1;
                    end
                end
`endif
            end
            RAMP: begin
                // Abort beats a step due on the same edge.
                if (i_abort) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (tgt > duty) begin
                        inc_n  = 1'b1;
                        duty_n = duty + 1'b1;
                    end else begin
                        dec_n  = 1'b1;
                        duty_n = duty - 1'b1;
                    end
                    if (duty_n == tgt) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            duty       <= DUTY_RST;
            tgt        <= DUTY_RST;
            o_increase <= 1'b0;
            o_decrease <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_n;
            duty       <= duty_n;
            tgt        <= tgt_n;
            o_increase <= inc_n;
            o_decrease <= dec_n;
            o_done     <= done_n;
        end
    end

    assign o_duty      = duty;
    assign o_tgt_ready = (state == IDLE);
    assign o_busy      = (state == RAMP);

endmodule
